// File: rtl/stream_demux_1_to_2.sv
// Buffered 1-to-2 stream router: each word is steered by in_sel (1 -> A, 0 -> B)
// into a per-port circular FIFO, so a stalled consumer never blocks the other port.
module stream_demux_1_to_2 #(
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_sel,
  output logic          a_valid,
  input  logic          a_ready,
  output logic [31:0]   a_data,
  output logic          b_valid,
  input  logic          b_ready,
  output logic [31:0]   b_data,
  output logic [CW-1:0] a_count,
  output logic [CW-1:0] b_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_OCC = DEPTH[AW:0];

  // Port index 0 is A, port index 1 is B.
  logic [31:0]   mem_q   [2][DEPTH];
  logic [AW-1:0] wr_q    [2];
  logic [AW-1:0] wr_d    [2];
  logic [AW-1:0] rd_q    [2];
  logic [AW-1:0] rd_d    [2];
  logic [AW:0]   occ_q   [2];
  logic [AW:0]   occ_d   [2];
  logic [CW-1:0] cnt_q   [2];
  logic [CW-1:0] cnt_d   [2];
  logic [1:0]    wrote_q;
  logic [1:0]    wrote_d;
  logic [1:0]    full;
  logic [1:0]    not_empty;
  logic [1:0]    push;
  logic [1:0]    pop;

  // Ready looks only at the selected FIFO's stored occupancy, never at same-cycle pops.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      full[p]      = (occ_q[p] == FULL_OCC);
      not_empty[p] = (occ_q[p] != '0);
    end
    in_ready = in_sel ? !full[0] : !full[1];
    push[0]  = in_valid && in_ready && in_sel;
    push[1]  = in_valid && in_ready && !in_sel;
    pop[0]   = not_empty[0] && a_ready;
    pop[1]   = not_empty[1] && b_ready;
  end

  always_comb begin
    wrote_d = wrote_q | push;
    for (int p = 0; p < 2; p++) begin
      wr_d[p]  = wr_q[p] + AW'(push[p]);
      rd_d[p]  = rd_q[p] + AW'(pop[p]);
      occ_d[p] = occ_q[p] + (AW+1)'(push[p]) - (AW+1)'(pop[p]);
      cnt_d[p] = (push[p] && (cnt_q[p] != '1)) ? cnt_q[p] + CW'(1) : cnt_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrote_q <= '0;
      for (int p = 0; p < 2; p++) begin
        wr_q[p]  <= '0;
        rd_q[p]  <= '0;
        occ_q[p] <= '0;
        cnt_q[p] <= '0;
      end
    end else begin
      wrote_q <= wrote_d;
      for (int p = 0; p < 2; p++) begin
        wr_q[p]  <= wr_d[p];
        rd_q[p]  <= rd_d[p];
        occ_q[p] <= occ_d[p];
        cnt_q[p] <= cnt_d[p];
      end
    end
  end

  // Storage carries no reset; the wrote flags mask stale contents after reset.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (push[p]) mem_q[p][wr_q[p]] <= in_data;
    end
  end

  assign a_valid = not_empty[0];
  assign b_valid = not_empty[1];
  assign a_data  = wrote_q[0] ? mem_q[0][rd_q[0]] : '0;
  assign b_data  = wrote_q[1] ? mem_q[1][rd_q[1]] : '0;
  assign a_count = cnt_q[0];
  assign b_count = cnt_q[1];

endmodule

// File: tb/tb_stream_demux_1_to_2.sv
// Randomized and directed bench for stream_demux_1_to_2 against a queue-based model.
module tb_stream_demux_1_to_2;

  localparam int DEPTH = 2;
  localparam int CW    = 16;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_sel;
  logic          a_valid;
  logic          a_ready;
  logic [31:0]   a_data;
  logic          b_valid;
  logic          b_ready;
  logic [31:0]   b_data;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  stream_demux_1_to_2 #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int unsigned ca, cb;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_ready(input logic s);
    return s ? (qa.size() < DEPTH) : (qb.size() < DEPTH);
  endfunction

  // One clock: drive, compare against the model mid-cycle, clock, then update the model.
  task automatic cycle(input logic v, input logic s, input logic [31:0] d,
                       input logic ar, input logic br);
    logic exp_rdy, acc, pa, pb;
    in_valid = v; in_sel = s; in_data = d; a_ready = ar; b_ready = br;
    @(negedge clk);
    exp_rdy = model_ready(s);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("a_valid", 32'(a_valid), 32'(qa.size() != 0));
    chk("b_valid", 32'(b_valid), 32'(qb.size() != 0));
    if (qa.size() != 0) chk("a_data", a_data, qa[0]);
    if (qb.size() != 0) chk("b_data", b_data, qb[0]);
    chk("a_count", 32'(a_count), ca);
    chk("b_count", 32'(b_count), cb);
    acc = v && exp_rdy;
    pa  = ar && (qa.size() != 0);
    pb  = br && (qb.size() != 0);
    @(posedge clk);
    #1;
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (s) begin qa.push_back(d); if (ca < CMAX) ca++; end
      else   begin qb.push_back(d); if (cb < CMAX) cb++; end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete(); qb.delete();
    ca = 0; cb = 0;
  endtask

  task automatic post_reset_checks();
    in_valid = 1'b0; a_ready = 1'b0; b_ready = 1'b0;
    in_sel = 1'b1; #1;
    chk("rst_rdy_sel1", 32'(in_ready), 32'd1);
    in_sel = 1'b0; #1;
    chk("rst_rdy_sel0", 32'(in_ready), 32'd1);
    chk("rst_a_valid", 32'(a_valid), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_b_data", b_data, 32'd0);
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_count", 32'(b_count), 32'd0);
  endtask

  initial begin
    logic v, s, stalled;
    logic [31:0] d;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0; a_ready = 1'b0; b_ready = 1'b0;
    ca = 0; cb = 0;

    do_reset(2);
    post_reset_checks();

    // Single word to each port.
    cycle(1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
    chk("a_first_valid", 32'(a_valid), 32'd1);
    chk("a_first_data", a_data, 32'hDEADBEEF);
    cycle(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b1);
    chk("b_first_data", b_data, 32'h12345678);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("cnt_a_one", 32'(a_count), 32'd1);
    chk("cnt_b_one", 32'(b_count), 32'd1);

    // Fill B with its consumer stalled, then redirect the stalled word to A.
    do_reset(1);
    for (int i = 0; i <= DEPTH; i++) cycle(1'b1, 1'b0, 32'h100 + i, 1'b0, 1'b0);
    in_sel = 1'b0; #1;
    chk("full_b_rdy", 32'(in_ready), 32'd0);
    in_sel = 1'b1; #1;
    chk("redirect_rdy", 32'(in_ready), 32'd1);
    cycle(1'b1, 1'b1, 32'h100 + DEPTH, 1'b0, 1'b0);
    chk("redirect_a_data", a_data, 32'h100 + DEPTH);
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("drain_b_count", 32'(b_count), DEPTH);

    // Back-to-back stream to A.
    do_reset(1);
    for (int i = 1; i <= 100; i++) cycle(1'b1, 1'b1, i, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b1);
    chk("stream_a_count", 32'(a_count), 32'd100);

    // Randomized traffic, honouring the hold rule during stalls.
    do_reset(1);
    stalled = 1'b0; d = '0;
    for (int n = 0; n < 10000; n++) begin
      s = 1'($urandom_range(0, 1));
      if (stalled) v = 1'b1;
      else begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom;
      end
      stalled = v && !model_ready(s);
      cycle(v, s, d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
    end
    repeat (DEPTH + 2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

    // Reset while both FIFOs hold two words, with consumers and producer active.
    do_reset(1);
    cycle(1'b1, 1'b1, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h12, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h21, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h22, 1'b0, 1'b0);
    chk("pre_rst_a_count", 32'(a_count), 32'd2);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h99; a_ready = 1'b1; b_ready = 1'b1;
    do_reset(1);
    post_reset_checks();
    cycle(1'b1, 1'b1, 32'h33, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h44, 1'b1, 1'b1);
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    chk("post_rst_a_count", 32'(a_count), 32'd1);
    chk("post_rst_b_count", 32'(b_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_demux_1_to_2.md
# stream_demux_1_to_2

Buffered 1-to-2 stream router for the MIPS datapath: the distributing counterpart of the 2-to-1 select mux. One 32-bit producer stream is steered, word by word, to one of two consumer ports by a per-word select bit. Each output has its own small FIFO, so a stalled consumer never blocks traffic bound for the other port. Typical use is splitting a result or writeback stream between two sinks, for example the register file and a memory-write queue.

## Interface
Parameters:
- DEPTH, 2: entries per output FIFO; a power of 2, minimum 2.
- CW, 16: width of the per-port accepted-word counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  the selected FIFO can take the word.
- in_data  input  32  word to route.
- in_sel  input  1  destination: 1 routes to port A, 0 routes to port B (same polarity as the 2-to-1 mux: sel ? A : B).
- a_valid  output  1  FIFO A head is valid.
- a_ready  input  1  consumer A takes the head.
- a_data  output  32  FIFO A head word.
- b_valid  output  1  FIFO B head is valid.
- b_ready  input  1  consumer B takes the head.
- b_data  output  32  FIFO B head word.
- a_count  output  CW  words accepted into A since reset; saturates at all-ones.
- b_count  output  CW  words accepted into B since reset; saturates at all-ones.

## Operation
- Input transfer: in_valid && in_ready at a rising edge.
- in_ready is combinational:
  - in_sel=1: in_ready = !full_A.
  - in_sel=0: in_ready = !full_B.
  - in_ready does not depend on in_valid.
  - in_ready does not depend on same-cycle pops. A full FIFO refuses the word even while its consumer is popping.
- Each FIFO:
  - Circular RAM of DEPTH x 32, with read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
  - Occupancy counter of log2(DEPTH)+1 bits.
  - full = (occ == DEPTH); empty = (occ == 0).
- Output transfer: x_valid && x_ready. Pops the head and advances the read pointer.
- x_valid = !empty_x. x_data = RAM[rdptr_x], registered storage.
- x_data is 0 when the FIFO has never been written since reset; otherwise it holds the last head value.
- Simultaneous push and pop on the same FIFO when not full:
  - Both pointers advance.
  - Occupancy is unchanged.
  - Word order is preserved.
- Simultaneous pop on A and push to B: independent, both occur.
- Ordering:
  - Strict FIFO order per port.
  - No ordering guarantee between ports.
- Counters increment by 1 on each accepted input transfer to their port and stick at 2^CW-1.
- Producer rule: in_data and in_sel must be held while in_valid && !in_ready. Changing in_sel during a stall is permitted; in_ready re-evaluates combinationally.
- Reset:
  - Both FIFOs empty, pointers 0, occupancy 0.
  - a_valid=b_valid=0, a_data=b_data=0, a_count=b_count=0.
  - in_ready=1 for either in_sel value.
  - Reset asserted mid-operation discards all buffered words at that edge. No output transfer is counted in the reset cycle.

## Timing
- Latency: a word accepted at edge N is visible as x_valid=1 with x_data=word after edge N; the consumer can take it at edge N+1.
- No combinational fall-through path from input to output.
- Throughput: one accepted word per cycle sustained to a single port while its consumer keeps x_ready=1 (occupancy stays at 1).
- Combinational paths:
  - in_sel → in_ready.
  - No path from x_ready to in_ready.
  - No path from in_valid to any output.
- Full condition: after DEPTH accepts with no pops, in_ready drops the following cycle for that in_sel value. It rises the cycle after the first pop.

## Test plan
- Reset with rst=1 for 2 cycles → a_valid=b_valid=0, a_count=b_count=0, in_ready=1 for both in_sel values.
- Route 0xDEADBEEF with sel=1, then 0x12345678 with sel=0, consumers ready → A gets 0xDEADBEEF one cycle after accept, B gets 0x12345678. Counts become 1 and 1.
- Hold b_ready=0 and send DEPTH+1 words with sel=0 → the first DEPTH are accepted and in_ready=0 on word DEPTH+1. Switching to sel=1 is accepted immediately. Releasing b_ready drains B in order.
- Back-to-back stream of 1..100 to port A with a_ready=1 → one accept per cycle, outputs in order 1..100, a_count=100, occupancy never exceeds 1.
- Random in_valid/in_sel/a_ready/b_ready for 10k cycles against a scoreboard → no loss, duplication or reordering per port.
- Assert rst with both FIFOs holding 2 words → next cycle both outputs invalid, counts 0, and subsequent traffic routes correctly.
- Optionally (CW=4): accept 20 words to A → a_count saturates at 15.
